// File: rtl/free_list_if.sv
// Free-list port bundle: rename-side allocation, commit-side release,
// flush restore and the architectural bitmap. The free list itself uses
// the slave modport; the rename/commit logic (or a bench) uses master.
interface free_list_if #(
  parameter int PHY_REG_NUM  = 64,
  parameter int DECODE_WIDTH = 2,
  parameter int COMMIT_WIDTH = 2
);
  localparam int P = $clog2(PHY_REG_NUM);

  logic                             alloc_valid_i;
  logic [DECODE_WIDTH-1:0]          alloc_req_i;
  logic                             alloc_ready_o;
  logic [DECODE_WIDTH-1:0][P-1:0]   preg_o;
  logic [COMMIT_WIDTH-1:0]          commit_valid_i;
  logic [COMMIT_WIDTH-1:0][P-1:0]   commit_pdest_i;
  logic [COMMIT_WIDTH-1:0]          commit_ppdst_valid_i;
  logic [COMMIT_WIDTH-1:0][P-1:0]   commit_ppdst_i;
  logic                             restore_i;
  logic [PHY_REG_NUM-1:0]           arch_valid_o;
  logic                             error_o;

  modport slave (
    input  alloc_valid_i, alloc_req_i,
    output alloc_ready_o, preg_o,
    input  commit_valid_i, commit_pdest_i, commit_ppdst_valid_i, commit_ppdst_i,
    input  restore_i,
    output arch_valid_o, error_o
  );

  modport master (
    output alloc_valid_i, alloc_req_i,
    input  alloc_ready_o, preg_o,
    output commit_valid_i, commit_pdest_i, commit_ppdst_valid_i, commit_ppdst_i,
    output restore_i,
    input  arch_valid_o, error_o
  );
endinterface

// File: rtl/free_list.sv
// Physical register free list for a register-renaming front end.
// Free pregs live in a circular queue indexed by head (next to allocate),
// tail (next free slot to fill) and arch_head (head position as seen by
// committed instructions). Pointers carry a wrap bit so that count =
// tail - head distinguishes full from empty. A flush rolls head back to
// arch_head, returning all speculatively allocated pregs in their
// original order.
// Optional protocol checking is compiled in with `define FREE_LIST_CHECK_EN;
// without it error_o is tied low.
module free_list #(
  parameter int PHY_REG_NUM  = 64,
  parameter int DECODE_WIDTH = 2,
  parameter int COMMIT_WIDTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  free_list_if.slave fl
);
  localparam int P  = $clog2(PHY_REG_NUM);
  localparam int PW = P + 1;

  logic [P-1:0]            queue_q [PHY_REG_NUM];
  logic [PW-1:0]           head_q, head_d;
  logic [PW-1:0]           tail_q, tail_d;
  logic [PW-1:0]           arch_head_q, arch_head_d;
  logic [PHY_REG_NUM-1:0]  arch_valid_q, arch_valid_d;
  logic [PW-1:0]           count;
  logic                    alloc_ready;
  logic                    alloc_fire;
  logic [PW-1:0]           alloc_ofs [DECODE_WIDTH+1];
  logic [PW-1:0]           free_ofs  [COMMIT_WIDTH+1];
  logic [PW-1:0]           commit_cnt;
  logic [COMMIT_WIDTH-1:0] free_en;

  // Number of set bits of v strictly below bit position n.
  function automatic logic [PW-1:0] ones_below(input logic [31:0] v, input int n);
    logic [PW-1:0] s;
    s = '0;
    for (int j = 0; j < 32; j++) begin
      if (j < n) s = s + PW'(v[j]);
    end
    return s;
  endfunction

  assign free_en    = fl.commit_valid_i & fl.commit_ppdst_valid_i;
  assign commit_cnt = ones_below(32'(fl.commit_valid_i), COMMIT_WIDTH);

  // Prefix counts compact the requesting lanes onto consecutive queue slots.
  for (genvar gi = 0; gi <= DECODE_WIDTH; gi++) begin : g_alloc_ofs
    assign alloc_ofs[gi] = ones_below(32'(fl.alloc_req_i), gi);
  end

  for (genvar gi = 0; gi <= COMMIT_WIDTH; gi++) begin : g_free_ofs
    assign free_ofs[gi] = ones_below(32'(free_en), gi);
  end

  // Allocation read is combinational so rename sees its pregs this cycle.
  for (genvar gi = 0; gi < DECODE_WIDTH; gi++) begin : g_preg
    assign fl.preg_o[gi] = queue_q[head_q[P-1:0] + alloc_ofs[gi][P-1:0]];
  end

  // Readiness depends only on registered pointers, never on this cycle's frees.
  assign count            = tail_q - head_q;
  assign alloc_ready      = (count >= PW'(DECODE_WIDTH));
  assign fl.alloc_ready_o = alloc_ready;
  assign alloc_fire       = fl.alloc_valid_i & alloc_ready & ~fl.restore_i;

  // Pointer next-state: restore overrides allocation and lands on the
  // post-commit architectural head.
  always_comb begin
    arch_head_d = arch_head_q + commit_cnt;
    tail_d      = tail_q + free_ofs[COMMIT_WIDTH];
    head_d      = head_q;
    if (fl.restore_i) begin
      head_d = arch_head_d;
    end else if (alloc_fire) begin
      head_d = head_q + alloc_ofs[DECODE_WIDTH];
    end
  end

  // Architectural bitmap: each committing lane in order drops its old
  // mapping then marks its new one, so a later lane can free an earlier
  // lane's pdest in the same cycle.
  always_comb begin
    arch_valid_d = arch_valid_q;
    for (int c = 0; c < COMMIT_WIDTH; c++) begin
      if (fl.commit_valid_i[c]) begin
        if (fl.commit_ppdst_valid_i[c]) arch_valid_d[fl.commit_ppdst_i[c]] = 1'b0;
        arch_valid_d[fl.commit_pdest_i[c]] = 1'b1;
      end
    end
  end

  assign fl.arch_valid_o = arch_valid_d;

  // Queue contents and pointers; reset refills the queue with every preg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHY_REG_NUM; i++) queue_q[i] <= P'(i);
      head_q       <= '0;
      arch_head_q  <= '0;
      tail_q       <= PW'(PHY_REG_NUM);
      arch_valid_q <= '0;
    end else begin
      for (int c = 0; c < COMMIT_WIDTH; c++) begin
        if (free_en[c]) begin
          queue_q[tail_q[P-1:0] + free_ofs[c][P-1:0]] <= fl.commit_ppdst_i[c];
        end
      end
      head_q       <= head_d;
      tail_q       <= tail_d;
      arch_head_q  <= arch_head_d;
      arch_valid_q <= arch_valid_d;
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic          error_q, error_d;
  logic [PW-1:0] count_d, inflight_d;

  // Flag allocation without room, queue overflow, or commits outrunning allocation.
  always_comb begin
    count_d    = tail_d - head_d;
    inflight_d = head_d - arch_head_d;
    error_d    = error_q
               | (fl.alloc_valid_i & ~alloc_ready)
               | (count_d > PW'(PHY_REG_NUM))
               | (inflight_d > PW'(PHY_REG_NUM));
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) error_q <= 1'b0;
    else        error_q <= error_d;
  end

  assign fl.error_o = error_q;
`else
  assign fl.error_o = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list. The reference model keeps the free list
// as a plain queue of preg numbers, the speculative (allocated, uncommitted)
// pregs as a second queue and the architectural bitmap as a bit vector.
// Directed scenarios come first, then randomized legal rename/commit traffic
// generated from an architectural map of 16 logical registers.
module tb_free_list;
  localparam int N  = 64;
  localparam int DW = 2;
  localparam int CW = 2;
  localparam int P  = 6;
`ifdef FREE_LIST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  free_list_if #(.PHY_REG_NUM(N), .DECODE_WIDTH(DW), .COMMIT_WIDTH(CW)) fl_if ();

  free_list #(.PHY_REG_NUM(N), .DECODE_WIDTH(DW), .COMMIT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fl    (fl_if)
  );

  typedef struct {
    bit [1:0]     req;
    bit           ready;
    int           p0;
    int           p1;
    bit [N-1:0]   archv;
    bit           err;
  } exp_t;

  exp_t       exp_q[$];
  int         fl_m[$];
  int         spec_m[$];
  bit [N-1:0] archv_m;
  bit         err_m;
  int         arch_map[16];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_txn    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    fl_m.delete();
    for (int i = 0; i < N; i++) fl_m.push_back(i);
    spec_m.delete();
    archv_m = '0;
    err_m   = 1'b0;
    for (int i = 0; i < 16; i++) arch_map[i] = -1;
  endtask

  // Drive one cycle of inputs, predict the response and queue it for the monitor.
  task automatic apply(input bit av, input bit [1:0] req, input bit [1:0] cv,
                       input int pd0, input int pd1, input bit [1:0] pv,
                       input int pp0, input int pp1, input bit rs);
    exp_t e;
    int   pd[2];
    int   pp[2];
    bit   ready;
    int   idx;
    pd[0] = pd0; pd[1] = pd1; pp[0] = pp0; pp[1] = pp1;
    fl_if.alloc_valid_i        = av;
    fl_if.alloc_req_i          = req;
    fl_if.commit_valid_i       = cv;
    fl_if.commit_pdest_i[0]    = P'(pd0);
    fl_if.commit_pdest_i[1]    = P'(pd1);
    fl_if.commit_ppdst_valid_i = pv;
    fl_if.commit_ppdst_i[0]    = P'(pp0);
    fl_if.commit_ppdst_i[1]    = P'(pp1);
    fl_if.restore_i            = rs;

    ready   = (fl_m.size() >= DW);
    e.req   = req;
    e.ready = ready;
    e.err   = CHK ? err_m : 1'b0;
    e.p0    = (fl_m.size() > 0) ? fl_m[0] : -1;
    idx     = req[0] ? 1 : 0;
    e.p1    = (fl_m.size() > idx) ? fl_m[idx] : -1;

    if (av && !ready) err_m = 1'b1;
    for (int c = 0; c < CW; c++) begin
      if (cv[c]) begin
        if (spec_m.size() == 0) err_m = 1'b1;
        else void'(spec_m.pop_front());
        if (pv[c]) archv_m[pp[c]] = 1'b0;
        archv_m[pd[c]] = 1'b1;
      end
    end
    if (av && ready && !rs) begin
      for (int l = 0; l < DW; l++) if (req[l]) spec_m.push_back(fl_m.pop_front());
    end
    for (int c = 0; c < CW; c++) if (cv[c] && pv[c]) fl_m.push_back(pp[c]);
    if (fl_m.size() > N) err_m = 1'b1;
    if (rs) begin
      for (int i = spec_m.size() - 1; i >= 0; i--) fl_m.push_front(spec_m[i]);
      spec_m.delete();
    end
    e.archv = archv_m;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    apply(1'b0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
    void'(exp_q.pop_back());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    chk("rst_ready", fl_if.alloc_ready_o, 1);
    chk("rst_error", fl_if.error_o, 0);
    chk("rst_arch_valid", fl_if.arch_valid_o, 0);
    chk("rst_preg0", fl_if.preg_o[0], 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One cycle of legal random traffic: commits follow allocation order and
  // release the old architectural mapping of a random logical register.
  task automatic rand_cycle();
    bit       rs, av;
    bit [1:0] req, cv, pv;
    int       pd[2];
    int       pp[2];
    int       k, l;
    rs  = ($urandom_range(0, 39) == 0);
    av  = (fl_m.size() >= DW) && ($urandom_range(0, 3) != 0);
    req = 2'($urandom_range(0, 3));
    cv = '0; pv = '0; pd[0] = 0; pd[1] = 0; pp[0] = 0; pp[1] = 0; k = 0;
    for (int c = 0; c < CW; c++) begin
      if (k < spec_m.size() && $urandom_range(0, 2) != 0) begin
        cv[c] = 1'b1;
        pd[c] = spec_m[k];
        k++;
        l = $urandom_range(0, 15);
        if (arch_map[l] >= 0) begin
          pv[c] = 1'b1;
          pp[c] = arch_map[l];
        end else begin
          pp[c] = $urandom_range(0, N - 1);
        end
        arch_map[l] = pd[c];
      end
    end
    apply(av, req, cv, pd[0], pd[1], pv, pp[0], pp[1], rs);
  endtask

  // Monitor: compare every presented cycle against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_txn++;
      $display("txn %0d req=%b ready=%0d preg1=%0d preg0=%0d arch=%h err=%0d", n_txn,
               e.req, fl_if.alloc_ready_o, fl_if.preg_o[1], fl_if.preg_o[0],
               fl_if.arch_valid_o, fl_if.error_o);
      chk("ready", fl_if.alloc_ready_o, e.ready);
      if (e.req[0] && e.p0 >= 0) chk("preg0", fl_if.preg_o[0], e.p0);
      if (e.req[1] && e.p1 >= 0) chk("preg1", fl_if.preg_o[1], e.p1);
      chk("arch_valid", fl_if.arch_valid_o, e.archv);
      chk("error", fl_if.error_o, e.err);
    end
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    do_reset();

    // First group allocation from reset, then a lane-1-only request.
    apply(1'b1, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
    mid();
    chk("d1_preg0", fl_if.preg_o[0], 0);
    chk("d1_preg1", fl_if.preg_o[1], 1);
    step();
    apply(1'b1, 2'b10, 2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
    mid();
    chk("d2_ready", fl_if.alloc_ready_o, 1);
    chk("d2_preg1", fl_if.preg_o[1], 2);
    step();
    apply(1'b1, 2'b01, 2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
    mid();
    chk("d2_head3", fl_if.preg_o[0], 3);
    step();

    // Drain completely, then release 5 and 9; they appear only a cycle later.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      apply(1'b1, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
      step();
    end
    apply(1'b0, 2'b00, 2'b11, 0, 1, 2'b11, 5, 9, 1'b0);
    mid();
    chk("d3_empty_ready", fl_if.alloc_ready_o, 0);
    step();
    apply(1'b1, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
    mid();
    chk("d3_ready", fl_if.alloc_ready_o, 1);
    chk("d3_preg0", fl_if.preg_o[0], 5);
    chk("d3_preg1", fl_if.preg_o[1], 9);
    step();

    // Flush with same-cycle commits of pregs 0 and 1.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
      step();
    end
    apply(1'b0, 2'b00, 2'b11, 0, 1, 2'b00, 0, 0, 1'b1);
    mid();
    chk("d4_arch_valid", fl_if.arch_valid_o, 64'h3);
    step();
    apply(1'b1, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
    mid();
    chk("d4_preg0", fl_if.preg_o[0], 2);
    chk("d4_preg1", fl_if.preg_o[1], 3);
    step();

    // Lane 1 frees the preg lane 0 just mapped in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
      step();
    end
    apply(1'b0, 2'b00, 2'b11, 5, 7, 2'b10, 0, 5, 1'b0);
    mid();
    chk("d5_arch5", fl_if.arch_valid_o[5], 0);
    chk("d5_arch7", fl_if.arch_valid_o[7], 1);
    step();
    for (int i = 0; i < 28; i++) begin
      apply(1'b1, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
      step();
    end
    apply(1'b0, 2'b01, 2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
    mid();
    chk("d5_queued5", fl_if.preg_o[0], 5);
    chk("d5_ready", fl_if.alloc_ready_o, 0);
    step();

    // Overfill by one release: sticky error when checking is compiled in.
    do_reset();
    apply(1'b0, 2'b00, 2'b01, 0, 0, 2'b01, 10, 0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
      mid();
      chk("d6_error_sticky", fl_if.error_o, 64'(CHK));
      step();
    end

    // Reset in the middle of an allocation cycle must leave no trace.
    do_reset();
    apply(1'b1, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
    @(negedge clk);
    #2;
    do_reset();
    apply(1'b0, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
    mid();
    chk("d7_preg0", fl_if.preg_o[0], 0);
    chk("d7_preg1", fl_if.preg_o[1], 1);
    step();

    // Randomized legal traffic.
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rand_cycle();
      step();
    end

    idle();
    mid();
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
